// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy counter, threshold flags
// and sticky overflow/underflow error flags.
module sync_fifo #(
    parameter int DATAWIDTH  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_TH   = (2 ** ADDR_WIDTH) - 1,
    parameter int AEMPTY_TH  = 1
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic [DATAWIDTH-1:0]  wdata,
    input  logic                  rinc,
    input  logic                  err_clr,
    output logic [DATAWIDTH-1:0]  rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C   = (ADDR_WIDTH+1)'(AFULL_TH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C  = (ADDR_WIDTH+1)'(AEMPTY_TH);

    logic [DATAWIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH:0]   count_nxt;

    // Flags come from the count register alone so they never combinationally
    // depend on this cycle's requests.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_acc = winc & ~full;
    assign rd_acc = rinc & ~empty;

    assign count_nxt = count + {{ADDR_WIDTH{1'b0}}, wr_acc}
                             - {{ADDR_WIDTH{1'b0}}, rd_acc};

    // Storage is deliberately left out of reset; the gate on wrst keeps a
    // write that coincides with reset from landing anywhere.
    always_ff @(posedge wclk) begin
        if (wr_acc && !wrst)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count  <= count_nxt;
            rvalid <= rd_acc;
            if (wr_acc)
                wptr <= wptr + 1'b1;
            if (rd_acc) begin
                rdata <= mem[rptr];
                rptr  <= rptr + 1'b1;
            end
            // Set beats clear when both happen in the same cycle.
            if (winc && full)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (rinc && empty)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end

endmodule
